// File: rtl/async_fifo_pkg.sv
// Shared helpers for both sides of the asynchronous FIFO.
// Gray conversions work on a 32-bit container; callers cast to their pointer width.
package async_fifo_pkg;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/async_fifo_sync.sv
// Multi-flop synchronizer that carries a Gray-coded pointer into the local clock domain.
module async_fifo_sync #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign q = stage[STAGES-1];

endmodule

// File: rtl/async_fifo_reader.sv
// Read side of an asynchronous FIFO: synchronizes the write pointer, pops the external
// RAM into a registered output stage and publishes its own pointer in Gray code.
module async_fifo_reader #(
   parameter int ADDR_WIDTH  = 3,
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH:0]   wptr_gray,
   output logic [ADDR_WIDTH:0]   rptr_gray,
   output logic [ADDR_WIDTH-1:0] raddr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   rd_count
);

   import async_fifo_pkg::*;

   localparam int PW = ADDR_WIDTH + 1;

   logic [PW-1:0] wptr_sync;
   logic [PW-1:0] rbin;
   logic [PW-1:0] rbin_next;
   logic          ram_empty;
   logic          pop;

   async_fifo_sync #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (wptr_gray),
      .q     (wptr_sync)
   );

   // rptr_gray always mirrors rbin, so comparing Gray pointers directly detects empty.
   assign ram_empty = (rptr_gray == wptr_sync);
   assign pop       = !ram_empty && (!m_valid || m_ready);
   assign rbin_next = rbin + PW'(pop);
   assign raddr     = rbin[ADDR_WIDTH-1:0];
   assign empty     = !m_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rbin      <= '0;
         rptr_gray <= '0;
         rd_count  <= '0;
         m_valid   <= 1'b0;
         m_data    <= '0;
      end else begin
         rbin      <= rbin_next;
         rptr_gray <= PW'(bin2gray(32'(rbin_next)));
         rd_count  <= PW'(gray2bin(32'(wptr_sync))) - rbin;
         if (pop) begin
            m_data  <= mem_rdata;
            m_valid <= 1'b1;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_async_fifo_reader.sv
// Self-checking bench for async_fifo_reader: a queue-based FIFO model drives the
// write pointer and external RAM, and checks output order, pointers and counts.
module tb_async_fifo_reader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] wptr_gray;
   logic [3:0] rptr_gray;
   logic [2:0] raddr;
   logic [7:0] mem_rdata;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic       empty;
   logic [3:0] rd_count;

   logic [7:0] mem [8];

   int         checks = 0;
   int         errors = 0;
   int         wbin;
   int         reads;
   int         accepted;
   logic [7:0] expq [$];
   logic [3:0] lastRptr;
   bit         sawWrap;

   async_fifo_reader #(
      .ADDR_WIDTH  (3),
      .DATA_WIDTH  (8),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wptr_gray (wptr_gray),
      .rptr_gray (rptr_gray),
      .raddr     (raddr),
      .mem_rdata (mem_rdata),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .empty     (empty),
      .rd_count  (rd_count)
   );

   assign mem_rdata = mem[raddr];

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [3:0] toGray(input int b);
      logic [3:0] v;
      v = 4'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Writer model: store into the RAM slot, then advance the Gray write pointer.
   task automatic applyStimulus(input logic [7:0] data);
      mem[3'(wbin % 8)] = data;
      expq.push_back(data);
      wbin++;
      wptr_gray = toGray(wbin);
   endtask

   task automatic resetModel();
      wbin     = 0;
      reads    = 0;
      accepted = 0;
      lastRptr = 4'd0;
      expq.delete();
   endtask

   // Every observed read-pointer move must be one Gray step to the next read index.
   task automatic trackPointer();
      if (rptr_gray !== lastRptr) begin
         checkOutput("rptr_onebit", 32'($countones(rptr_gray ^ lastRptr)), 32'd1);
         reads++;
         checkOutput("rptr_gray", 32'(rptr_gray), 32'(toGray(reads)));
         checkOutput("raddr", 32'(raddr), 32'(reads % 8));
         if (reads % 16 == 0) sawWrap = 1'b1;
         lastRptr = rptr_gray;
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n     = 1'b0;
      wptr_gray = 4'd0;
      m_ready   = 1'b0;
      resetModel();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic runTraffic(input int pushes, input int budget, input int readyPct);
      int pushed = 0;
      int cyc    = 0;
      while ((pushed < pushes || expq.size() > 0) && cyc < budget) begin
         @(negedge clk);
         cyc++;
         trackPointer();
         m_ready = ($urandom_range(99) < readyPct);
         if (m_valid && m_ready) begin
            if (expq.size() == 0) begin
               checkOutput("spurious_valid", 32'(m_valid), 32'd0);
            end else begin
               checkOutput("data_order", 32'(m_data), 32'(expq.pop_front()));
               accepted++;
            end
         end
         if (pushed < pushes && (wbin - accepted) < 8 && $urandom_range(1) == 1) begin
            applyStimulus(8'($urandom));
            pushed++;
         end
      end
      checkOutput("traffic_done", 32'(cyc < budget), 32'd1);
      checkOutput("all_read", 32'(reads), 32'(wbin));
   endtask

   initial begin
      logic [7:0] streamData [8];
      logic [7:0] hold;
      int         cyc;

      for (int i = 0; i < 8; i++) mem[i] = 8'h00;
      resetModel();
      sawWrap   = 1'b0;
      rst_n     = 1'b0;
      m_ready   = 1'b0;
      wptr_gray = 4'b0110;

      // Reset state with a nonzero write pointer present.
      repeat (2) @(negedge clk);
      checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
      checkOutput("rst_empty", 32'(empty), 32'd1);
      checkOutput("rst_rptr_gray", 32'(rptr_gray), 32'd0);
      checkOutput("rst_raddr", 32'(raddr), 32'd0);
      checkOutput("rst_rd_count", 32'(rd_count), 32'd0);
      checkOutput("rst_m_data", 32'(m_data), 32'd0);
      wptr_gray = 4'd0;
      @(negedge clk);
      rst_n = 1'b1;

      // Single write with consumer stalled.
      @(negedge clk);
      applyStimulus(8'hA5);
      @(negedge clk); trackPointer();
      @(negedge clk); trackPointer();
      checkOutput("single_early", 32'(m_valid), 32'd0);
      @(negedge clk); trackPointer();
      checkOutput("single_valid", 32'(m_valid), 32'd1);
      checkOutput("single_data", 32'(m_data), 32'hA5);
      checkOutput("single_rptr", 32'(rptr_gray), 32'd1);
      repeat (2) begin @(negedge clk); trackPointer(); end
      checkOutput("single_hold", 32'(m_data), 32'hA5);
      checkOutput("single_count", 32'(rd_count), 32'd0);
      runTraffic(0, 20, 100);
      @(negedge clk); trackPointer();
      checkOutput("single_drained", 32'(empty), 32'd1);

      // Full FIFO streamed out at one entry per clock.
      doReset();
      for (int i = 0; i < 8; i++) begin
         streamData[i] = 8'($urandom);
         mem[i]        = streamData[i];
      end
      wbin      = 8;
      wptr_gray = 4'b1100;
      m_ready   = 1'b1;
      cyc = 0;
      while (!m_valid && cyc < 10) begin
         @(negedge clk);
         trackPointer();
         cyc++;
      end
      checkOutput("stream_latency", 32'(cyc), 32'd3);
      for (int i = 0; i < 8; i++) begin
         checkOutput("stream_valid", 32'(m_valid), 32'd1);
         checkOutput("stream_data", 32'(m_data), 32'(streamData[i]));
         accepted++;
         @(negedge clk);
         trackPointer();
      end
      checkOutput("stream_empty", 32'(empty), 32'd1);
      repeat (2) begin @(negedge clk); trackPointer(); end
      checkOutput("stream_count", 32'(rd_count), 32'd0);
      checkOutput("stream_reads", 32'(reads), 32'd8);

      // Backpressure: three entries queued, consumer stalled for five cycles.
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(8'($urandom));
      repeat (3) begin @(negedge clk); trackPointer(); end
      checkOutput("bp_valid", 32'(m_valid), 32'd1);
      checkOutput("bp_first", 32'(m_data), 32'(expq[0]));
      hold = m_data;
      repeat (5) begin
         @(negedge clk);
         trackPointer();
         checkOutput("bp_stable", 32'(m_data), 32'(hold));
      end
      checkOutput("bp_one_pop", 32'(reads), 32'(wbin - 2));
      checkOutput("bp_raddr", 32'(raddr), 32'((wbin - 2) % 8));
      checkOutput("bp_count", 32'(rd_count), 32'd2);
      runTraffic(0, 40, 100);

      // Randomized traffic that carries the read pointer through its wrap.
      sawWrap = 1'b0;
      runTraffic(20, 800, 60);
      checkOutput("wrap_seen", 32'(sawWrap), 32'd1);

      // Reset asserted between clock edges while the output stage is loaded.
      @(negedge clk);
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus(8'($urandom));
      repeat (6) begin @(negedge clk); trackPointer(); end
      checkOutput("mid_pre_valid", 32'(m_valid), 32'd1);
      checkOutput("mid_pre_count", 32'(rd_count), 32'd4);
      #2;
      rst_n     = 1'b0;
      wptr_gray = 4'd0;
      #1;
      checkOutput("mid_m_valid", 32'(m_valid), 32'd0);
      checkOutput("mid_empty", 32'(empty), 32'd1);
      checkOutput("mid_raddr", 32'(raddr), 32'd0);
      checkOutput("mid_rptr", 32'(rptr_gray), 32'd0);
      checkOutput("mid_count", 32'(rd_count), 32'd0);
      checkOutput("mid_m_data", 32'(m_data), 32'd0);
      resetModel();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(8'h3C);
      runTraffic(0, 20, 100);
      checkOutput("post_rst_raddr", 32'(raddr), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
